// File: rtl/riscv_fetch_ctrl_pkg.sv
// Shared types and defaults for the IF-stage fetch controller.
package riscv_fetch_ctrl_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_TRAP_PC  = 32'h0000_0100;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StReq   = 2'd1,
    StHold  = 2'd2,
    StFlush = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/riscv_fetch_ctrl_adder.sv
// Plain XLEN-bit adder; the carry out is discarded so results wrap modulo 2^XLEN.
module riscv_fetch_ctrl_adder
  import riscv_fetch_ctrl_pkg::*;
(
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  output logic [XLEN-1:0] sum_o
);

  assign sum_o = op_a_i + op_b_i;

endmodule

// File: rtl/riscv_fetch_ctrl.sv
// IF-stage fetch sequencer: owns the PC, runs the imem req/ack handshake and presents
// {instr, pc, pc4} to ID. Define RISCV_FETCH_MISALIGN_EN to trap misaligned redirects.
module riscv_fetch_ctrl
  import riscv_fetch_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [XLEN-1:0] TRAP_PC  = DEFAULT_TRAP_PC
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_ack,
  input  logic [XLEN-1:0] i_imem_rdata,
  output logic            o_if_valid,
  input  logic            i_id_ready,
  output logic [XLEN-1:0] o_if_instr,
  output logic [XLEN-1:0] o_if_pc,
  output logic [XLEN-1:0] o_if_pc4,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_if_misalign
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_q, pend_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_inc;
  logic [XLEN-1:0] redirect_tgt;

`ifdef RISCV_FETCH_MISALIGN_EN
  logic misalign_q;
  logic tgt_misaligned;

  assign tgt_misaligned = |i_redirect_pc[1:0];
  assign redirect_tgt   = tgt_misaligned ? TRAP_PC : i_redirect_pc;

  // Pulse appears the cycle after the redirect edge, whatever state absorbed it.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= i_redirect & tgt_misaligned;
    end
  end

  assign o_if_misalign = misalign_q;
`else
  logic unused_misalign_inputs;

  assign redirect_tgt           = {i_redirect_pc[XLEN-1:2], 2'b00};
  assign unused_misalign_inputs = ^{TRAP_PC, i_redirect_pc[1:0]};
  assign o_if_misalign          = 1'b0;
`endif

  riscv_fetch_ctrl_adder u_pc_inc (
    .op_a_i (pc_q),
    .op_b_i (32'd4),
    .sum_o  (pc_inc)
  );

  riscv_fetch_ctrl_adder u_pc4 (
    .op_a_i (if_pc_q),
    .op_b_i (32'd4),
    .sum_o  (o_if_pc4)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    instr_d = instr_q;
    if_pc_d = if_pc_q;
    valid_d = valid_q;

    unique case (state_q)
      StIdle: begin
        state_d = StReq;
        if (i_redirect) pc_d = redirect_tgt;
      end
      StReq: begin
        if (i_redirect) begin
          if (i_imem_ack) begin
            pc_d = redirect_tgt;
          end else begin
            // Request cannot be withdrawn: park the target until the old word returns.
            pend_d  = redirect_tgt;
            state_d = StFlush;
          end
        end else if (i_imem_ack) begin
          instr_d = i_imem_rdata;
          if_pc_d = pc_q;
          valid_d = 1'b1;
          state_d = StHold;
        end
      end
      StHold: begin
        if (i_redirect) begin
          pc_d    = redirect_tgt;
          valid_d = 1'b0;
          state_d = StReq;
        end else if (i_id_ready) begin
          pc_d    = pc_inc;
          valid_d = 1'b0;
          state_d = StReq;
        end
      end
      StFlush: begin
        if (i_imem_ack) begin
          pc_d    = i_redirect ? redirect_tgt : pend_q;
          state_d = StReq;
        end else if (i_redirect) begin
          pend_d = redirect_tgt;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
      instr_q <= '0;
      if_pc_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      instr_q <= instr_d;
      if_pc_q <= if_pc_d;
      valid_q <= valid_d;
    end
  end

  assign o_imem_req  = (state_q == StReq) || (state_q == StFlush);
  assign o_imem_addr = pc_q;
  assign o_if_valid  = valid_q;
  assign o_if_instr  = instr_q;
  assign o_if_pc     = if_pc_q;

endmodule
